// File: rtl/client_rx.sv
// Network sink: it accepts flits addressed to this PE, tracks per-source sequence order
// and keeps saturating statistics until LIMIT packets have been accepted.
module client_rx #(
    parameter int N     = 32,
    parameter int D_W   = 32,
    parameter int A_W   = $clog2(N) + 1,
    parameter int posx  = 0,
    parameter int LIMIT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 start,
    input  logic [A_W+D_W+1:0]   i,
    output logic [31:0]          rcvd_cnt,
    output logic [31:0]          err_route,
    output logic [31:0]          err_seq,
    output logic [$clog2(N)-1:0] last_src,
    output logic                 busy,
    output logic                 done
);

    localparam int SRC_W = $clog2(N);
    localparam int SW    = D_W - SRC_W;
    localparam logic [A_W-1:0] MY_ADDR = A_W'(posx);
    localparam logic [31:0]    LIMIT_V = 32'(LIMIT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             rcvd_cnt_q, rcvd_cnt_d;
    logic [31:0]             err_route_q, err_route_d;
    logic [31:0]             err_seq_q, err_seq_d;
    logic [SRC_W-1:0]        last_src_q, last_src_d;
    logic [N-1:0][SW-1:0]    exp_q, exp_d;

    logic                    flit_valid;
    logic [A_W-1:0]          flit_addr;
    logic [SRC_W-1:0]        flit_src;
    logic [SW-1:0]           flit_seq;
    logic                    tbl_upd;
    logic                    tbl_clr;

    assign flit_valid = i[A_W+D_W+1];
    assign flit_addr  = i[A_W+D_W-1:D_W];
    assign flit_src   = i[D_W-1:SW];
    assign flit_seq   = i[SW-1:0];

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        rcvd_cnt_d  = rcvd_cnt_q;
        err_route_d = err_route_q;
        err_seq_d   = err_seq_q;
        last_src_d  = last_src_q;
        tbl_upd     = 1'b0;
        tbl_clr     = 1'b0;
        if (ce) begin
            case (state_q)
                IDLE: begin
                    if (start) state_d = RUN;
                end
                RUN: begin
                    if (flit_valid) begin
                        if (flit_addr != MY_ADDR) begin
                            err_route_d = sat_inc(err_route_q);
                        end else begin
                            tbl_upd    = 1'b1;
                            rcvd_cnt_d = sat_inc(rcvd_cnt_q);
                            last_src_d = flit_src;
                            if (flit_seq != exp_q[flit_src]) err_seq_d = sat_inc(err_seq_q);
                            if (rcvd_cnt_d == LIMIT_V) state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    // Re-arming starts a fresh measurement run.
                    if (start) begin
                        state_d     = RUN;
                        rcvd_cnt_d  = '0;
                        err_route_d = '0;
                        err_seq_d   = '0;
                        tbl_clr     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Each entry resyncs to the sequence after the one just seen from its source.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_tbl
            always_comb begin
                exp_d[gi] = exp_q[gi];
                if (tbl_clr)
                    exp_d[gi] = '0;
                else if (tbl_upd && (flit_src == SRC_W'(gi)))
                    exp_d[gi] = flit_seq + SW'(1);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rcvd_cnt_q  <= '0;
            err_route_q <= '0;
            err_seq_q   <= '0;
            last_src_q  <= '0;
            exp_q       <= '0;
        end else begin
            state_q     <= state_d;
            rcvd_cnt_q  <= rcvd_cnt_d;
            err_route_q <= err_route_d;
            err_seq_q   <= err_seq_d;
            last_src_q  <= last_src_d;
            exp_q       <= exp_d;
        end
    end

    assign rcvd_cnt  = rcvd_cnt_q;
    assign err_route = err_route_q;
    assign err_seq   = err_seq_q;
    assign last_src  = last_src_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_client_rx.sv
// Directed bench for client_rx: two instances (large and small LIMIT) share one stimulus.
module tb_client_rx;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        start;
    logic [21:0] i;

    logic [31:0] rcvd_cnt, err_route, err_seq;
    logic [2:0]  last_src;
    logic        busy, done;
    logic [31:0] l_rcvd_cnt, l_err_route, l_err_seq;
    logic [2:0]  l_last_src;
    logic        l_busy, l_done;

    int checks;
    int failures;

    client_rx #(.N(8), .D_W(16), .A_W(4), .posx(0), .LIMIT(1024)) dut (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .i(i),
        .rcvd_cnt(rcvd_cnt), .err_route(err_route), .err_seq(err_seq),
        .last_src(last_src), .busy(busy), .done(done)
    );

    client_rx #(.N(8), .D_W(16), .A_W(4), .posx(0), .LIMIT(4)) dut_lim (
        .clk(clk), .rst(rst), .ce(ce), .start(start), .i(i),
        .rcvd_cnt(l_rcvd_cnt), .err_route(l_err_route), .err_seq(l_err_seq),
        .last_src(l_last_src), .busy(l_busy), .done(l_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Presents one flit for exactly one rising edge; call and return on a falling edge.
    task automatic drive(input logic v, input logic [3:0] a, input logic [2:0] s,
                         input logic [12:0] q, input logic c);
        i  = {v, 1'b0, a, s, q};
        ce = c;
        @(negedge clk);
        i  = '0;
        ce = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic reset_and_start();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pulse_start();
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (rcvd_cnt !== 32'd0 || err_route !== 32'd0 || err_seq !== 32'd0) begin
            failures++;
            $display("FAIL reset_counters got=%0d/%0d/%0d exp=0/0/0", rcvd_cnt, err_route, err_seq);
        end
        checks++;
        if (last_src !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=src%0d busy%0b done%0b exp=src0 busy0 done0", last_src, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(1'b1, 4'd0, 3'd2, 13'd0, 1'b1);
        checks++;
        if (rcvd_cnt !== 32'd0 || busy !== 1'b0 || last_src !== 3'd0) begin
            failures++;
            $display("FAIL idle_ignores got=rcvd%0d busy%0b src%0d exp=rcvd0 busy0 src0", rcvd_cnt, busy, last_src);
        end
        $display("test_reset done");
    endtask

    task automatic test_in_order();
        reset_and_start();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL start_busy got=%0b exp=1", busy);
        end
        for (int k = 0; k < 4; k++) drive(1'b1, 4'd0, 3'd3, 13'(k), 1'b1);
        pulse_start();
        checks++;
        if (rcvd_cnt !== 32'd4) begin
            failures++;
            $display("FAIL in_order_rcvd got=%0d exp=4", rcvd_cnt);
        end
        checks++;
        if (err_seq !== 32'd0 || err_route !== 32'd0) begin
            failures++;
            $display("FAIL in_order_errs got=%0d/%0d exp=0/0", err_seq, err_route);
        end
        checks++;
        if (last_src !== 3'd3 || busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL in_order_state got=src%0d busy%0b done%0b exp=src3 busy1 done0", last_src, busy, done);
        end
        $display("test_in_order done");
    endtask

    task automatic test_route();
        reset_and_start();
        drive(1'b1, 4'd5, 3'd6, 13'd9, 1'b1);
        checks++;
        if (err_route !== 32'd1 || rcvd_cnt !== 32'd0 || last_src !== 3'd0) begin
            failures++;
            $display("FAIL route_err got=err%0d rcvd%0d src%0d exp=err1 rcvd0 src0", err_route, rcvd_cnt, last_src);
        end
        drive(1'b1, 4'd0, 3'd6, 13'd0, 1'b1);
        checks++;
        if (err_seq !== 32'd0 || rcvd_cnt !== 32'd1 || last_src !== 3'd6) begin
            failures++;
            $display("FAIL route_table got=seq%0d rcvd%0d src%0d exp=seq0 rcvd1 src6", err_seq, rcvd_cnt, last_src);
        end
        drive(1'b0, 4'd0, 3'd6, 13'd5, 1'b1);
        checks++;
        if (rcvd_cnt !== 32'd1 || err_seq !== 32'd0) begin
            failures++;
            $display("FAIL invalid_ignored got=rcvd%0d seq%0d exp=rcvd1 seq0", rcvd_cnt, err_seq);
        end
        $display("test_route done");
    endtask

    task automatic test_seq();
        reset_and_start();
        drive(1'b1, 4'd0, 3'd2, 13'd0, 1'b1);
        drive(1'b1, 4'd0, 3'd2, 13'd2, 1'b1);
        checks++;
        if (err_seq !== 32'd1) begin
            failures++;
            $display("FAIL seq_gap got=%0d exp=1", err_seq);
        end
        drive(1'b1, 4'd0, 3'd2, 13'd3, 1'b1);
        checks++;
        if (err_seq !== 32'd1 || rcvd_cnt !== 32'd3 || last_src !== 3'd2) begin
            failures++;
            $display("FAIL seq_resync got=seq%0d rcvd%0d src%0d exp=seq1 rcvd3 src2", err_seq, rcvd_cnt, last_src);
        end
        drive(1'b1, 4'd0, 3'd2, 13'd4, 1'b1);
        checks++;
        if (err_seq !== 32'd1 || rcvd_cnt !== 32'd4) begin
            failures++;
            $display("FAIL seq_expect4 got=seq%0d rcvd%0d exp=seq1 rcvd4", err_seq, rcvd_cnt);
        end
        drive(1'b1, 4'd0, 3'd2, 13'd4, 1'b1);
        checks++;
        if (err_seq !== 32'd2) begin
            failures++;
            $display("FAIL seq_repeat got=%0d exp=2", err_seq);
        end
        $display("test_seq done");
    endtask

    task automatic test_ce_interleave();
        reset_and_start();
        drive(1'b1, 4'd0, 3'd1, 13'd0, 1'b1);
        drive(1'b1, 4'd0, 3'd7, 13'd0, 1'b1);
        drive(1'b1, 4'd0, 3'd1, 13'd1, 1'b0);
        checks++;
        if (rcvd_cnt !== 32'd2 || last_src !== 3'd7) begin
            failures++;
            $display("FAIL ce_low_drop got=rcvd%0d src%0d exp=rcvd2 src7", rcvd_cnt, last_src);
        end
        drive(1'b1, 4'd0, 3'd1, 13'd1, 1'b1);
        drive(1'b1, 4'd5, 3'd7, 13'd1, 1'b0);
        checks++;
        if (err_route !== 32'd0) begin
            failures++;
            $display("FAIL ce_low_route got=%0d exp=0", err_route);
        end
        drive(1'b1, 4'd0, 3'd7, 13'd1, 1'b1);
        drive(1'b1, 4'd0, 3'd1, 13'd2, 1'b1);
        drive(1'b1, 4'd0, 3'd7, 13'd2, 1'b1);
        checks++;
        if (rcvd_cnt !== 32'd6 || err_seq !== 32'd0 || last_src !== 3'd7) begin
            failures++;
            $display("FAIL interleave got=rcvd%0d seq%0d src%0d exp=rcvd6 seq0 src7", rcvd_cnt, err_seq, last_src);
        end
        start = 1'b1;
        ce    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ce    = 1'b1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL ce_low_start got=busy%0b exp=busy1", busy);
        end
        $display("test_ce_interleave done");
    endtask

    task automatic test_limit();
        reset_and_start();
        for (int k = 0; k < 3; k++) drive(1'b1, 4'd0, 3'd1, 13'(k), 1'b1);
        checks++;
        if (l_done !== 1'b0 || l_busy !== 1'b1 || l_rcvd_cnt !== 32'd3) begin
            failures++;
            $display("FAIL limit_pre got=done%0b busy%0b rcvd%0d exp=done0 busy1 rcvd3", l_done, l_busy, l_rcvd_cnt);
        end
        drive(1'b1, 4'd0, 3'd1, 13'd3, 1'b1);
        checks++;
        if (l_done !== 1'b1 || l_busy !== 1'b0 || l_rcvd_cnt !== 32'd4) begin
            failures++;
            $display("FAIL limit_hit got=done%0b busy%0b rcvd%0d exp=done1 busy0 rcvd4", l_done, l_busy, l_rcvd_cnt);
        end
        drive(1'b1, 4'd0, 3'd5, 13'd7, 1'b1);
        checks++;
        if (l_rcvd_cnt !== 32'd4 || l_last_src !== 3'd1 || l_err_seq !== 32'd0 || l_done !== 1'b1) begin
            failures++;
            $display("FAIL limit_after got=rcvd%0d src%0d seq%0d done%0b exp=rcvd4 src1 seq0 done1",
                     l_rcvd_cnt, l_last_src, l_err_seq, l_done);
        end
        pulse_start();
        checks++;
        if (l_rcvd_cnt !== 32'd0 || l_busy !== 1'b1 || l_done !== 1'b0) begin
            failures++;
            $display("FAIL rearm got=rcvd%0d busy%0b done%0b exp=rcvd0 busy1 done0", l_rcvd_cnt, l_busy, l_done);
        end
        drive(1'b1, 4'd0, 3'd1, 13'd0, 1'b1);
        checks++;
        if (l_err_seq !== 32'd0 || l_rcvd_cnt !== 32'd1) begin
            failures++;
            $display("FAIL rearm_table got=seq%0d rcvd%0d exp=seq0 rcvd1", l_err_seq, l_rcvd_cnt);
        end
        $display("test_limit done");
    endtask

    task automatic test_reset_midrun();
        reset_and_start();
        for (int k = 0; k < 10; k++) drive(1'b1, 4'd0, 3'd4, 13'(k), 1'b1);
        drive(1'b1, 4'd9, 3'd4, 13'd10, 1'b1);
        drive(1'b1, 4'd0, 3'd4, 13'd12, 1'b1);
        checks++;
        if (rcvd_cnt !== 32'd11 || err_route !== 32'd1 || err_seq !== 32'd1) begin
            failures++;
            $display("FAIL midrun_pre got=rcvd%0d route%0d seq%0d exp=rcvd11 route1 seq1", rcvd_cnt, err_route, err_seq);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (rcvd_cnt !== 32'd0 || err_route !== 32'd0 || err_seq !== 32'd0 ||
            last_src !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got=rcvd%0d route%0d seq%0d src%0d busy%0b done%0b exp=all0",
                     rcvd_cnt, err_route, err_seq, last_src, busy, done);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(1'b1, 4'd0, 3'd4, 13'd0, 1'b1);
        checks++;
        if (busy !== 1'b0 || rcvd_cnt !== 32'd0) begin
            failures++;
            $display("FAIL post_reset_idle got=busy%0b rcvd%0d exp=busy0 rcvd0", busy, rcvd_cnt);
        end
        pulse_start();
        drive(1'b1, 4'd0, 3'd4, 13'd0, 1'b1);
        checks++;
        if (err_seq !== 32'd0 || rcvd_cnt !== 32'd1 || last_src !== 3'd4) begin
            failures++;
            $display("FAIL post_reset_seq got=seq%0d rcvd%0d src%0d exp=seq0 rcvd1 src4", err_seq, rcvd_cnt, last_src);
        end
        $display("test_reset_midrun done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        ce       = 1'b1;
        start    = 1'b0;
        i        = '0;
        test_reset();
        test_in_order();
        test_route();
        test_seq();
        test_ce_interleave();
        test_limit();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
